// File: rtl/phy_dly_sequencer.sv
// Queues (addr,tap) writes and replays them to phy_top as ld_delay strobes, then set, settle and done.
// Optional shadow readback of loaded taps: define PHY_DLY_SEQ_READBACK_EN.
module phy_dly_sequencer #(
    parameter int FIFO_DEPTH    = 8,
    parameter int LD_GAP        = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic       busy,
    output logic       done,
    output logic [6:0] dly_addr,
    output logic [7:0] dly_data,
    output logic       ld_delay,
    output logic       set,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_SET    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] GAP_LAST    = 4'(LD_GAP - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [6:0]    fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] n_load;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [3:0]    gap_cnt;
    logic [7:0]    settle_cnt;
    logic          commit_pending;
    logic          push;
    logic          pop;
    logic          leave_idle;

    // wr_ready is the registered !full, so a pop while full cannot admit a push that cycle
    assign push       = wr_valid && wr_ready;
    assign pop        = (state == S_LOAD);
    assign leave_idle = (state == S_IDLE) && (state_nxt != S_IDLE);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (commit_pending)
                    state_nxt = (count != '0) ? S_LOAD : S_SET;
            end
            S_LOAD: begin
                if (LD_GAP != 0)
                    state_nxt = S_GAP;
                else if (n_load > CW'(1))
                    state_nxt = S_LOAD;
                else
                    state_nxt = S_SET;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = (n_load != '0) ? S_LOAD : S_SET;
            end
            S_SET:    state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wr_ready       <= 1'b1;
            state          <= S_IDLE;
            n_load         <= '0;
            gap_cnt        <= '0;
            settle_cnt     <= '0;
            commit_pending <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ld_delay       <= 1'b0;
            set            <= 1'b0;
            dly_addr       <= '0;
            dly_data       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            wr_ready <= (count_nxt != CW'(FIFO_DEPTH));

            state <= state_nxt;
            // Outputs lag the state by one cycle; busy also covers the done cycle.
            busy     <= (state_nxt != S_IDLE) || (state == S_DONE);
            ld_delay <= (state == S_LOAD);
            set      <= (state == S_SET);
            done     <= (state == S_DONE);

            if (state == S_LOAD) begin
                dly_addr <= fifo_addr[rd_ptr];
                dly_data <= fifo_data[rd_ptr];
            end

            if (leave_idle)
                n_load <= count;
            else if (state == S_LOAD)
                n_load <= n_load - CW'(1);

            if (commit)
                commit_pending <= 1'b1;
            else if (leave_idle)
                commit_pending <= 1'b0;

            gap_cnt    <= (state == S_GAP) ? gap_cnt + 4'd1 : '0;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : '0;
        end
    end

`ifdef PHY_DLY_SEQ_READBACK_EN
    logic [7:0] shadow [128];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 128; i++)
                shadow[i] <= '0;
            rd_data <= '0;
        end else begin
            if (ld_delay)
                shadow[dly_addr] <= dly_data;
            rd_data <= shadow[rd_addr];
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else
            rd_data <= '0;
    end
`endif

endmodule

// File: tb/tb_phy_dly_sequencer.sv
// Directed bench for phy_dly_sequencer at default parameters (FIFO_DEPTH=8, LD_GAP=1, SETTLE_CYCLES=4).
// Cycle numbers are counted in mclk edges after the edge that samples commit.
module tb_phy_dly_sequencer;

    logic       mclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] dly_addr;
    logic [7:0] dly_data;
    logic       ld_delay;
    logic       set;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data;

    always #5 mclk = ~mclk;

    phy_dly_sequencer #(
        .FIFO_DEPTH    (8),
        .LD_GAP        (1),
        .SETTLE_CYCLES (4)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .busy     (busy),
        .done     (done),
        .dly_addr (dly_addr),
        .dly_data (dly_data),
        .ld_delay (ld_delay),
        .set      (set),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int         ld_cyc [$];
    logic [6:0] ld_a   [$];
    logic [7:0] ld_d   [$];
    int         set_cyc  [$];
    int         done_cyc [$];
    logic       rdy_at [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic push(input logic [6:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic clear_obs();
        ld_cyc.delete();
        ld_a.delete();
        ld_d.delete();
        set_cyc.delete();
        done_cyc.delete();
        for (int i = 0; i < 64; i++)
            rdy_at[i] = 1'bx;
    endtask

    task automatic sample(input int c);
        if (ld_delay) begin
            ld_cyc.push_back(c);
            ld_a.push_back(dly_addr);
            ld_d.push_back(dly_data);
        end
        if (set)
            set_cyc.push_back(c);
        if (done)
            done_cyc.push_back(c);
        if (c < 64)
            rdy_at[c] = wr_ready;
    endtask

    task automatic observe(input int ncyc);
        clear_obs();
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            sample(c);
        end
    endtask

    task automatic chk_ld(input string tag, input int idx, input int cyc,
                          input logic [6:0] a, input logic [7:0] d);
        if (ld_cyc.size() > idx) begin
            chk($sformatf("%s_cyc", tag), ld_cyc[idx], cyc);
            chk($sformatf("%s_addr", tag), ld_a[idx], a);
            chk($sformatf("%s_data", tag), ld_d[idx], d);
        end else begin
            chk($sformatf("%s_present", tag), 0, 1);
        end
    endtask

    task automatic chk_at(input string tag, input int q[$], input int idx, input int cyc);
        if (q.size() > idx)
            chk(tag, q[idx], cyc);
        else
            chk($sformatf("%s_present", tag), 0, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dly_addr", dly_addr, 0);
        chk("rst_dly_data", dly_data, 0);
        chk("rst_ld_delay", ld_delay, 0);
        chk("rst_set", set, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Two entries, commit from idle
        push(7'h05, 8'h2A);
        push(7'h11, 8'h7F);
        do_commit();
        chk("t1_busy_c0", busy, 0);
        clear_obs();
        for (int c = 1; c <= 13; c++) begin
            tick();
            sample(c);
            chk($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 11) ? 1 : 0);
        end
        chk("t1_ld_count", ld_cyc.size(), 2);
        chk_ld("t1_ld0", 0, 2, 7'h05, 8'h2A);
        chk_ld("t1_ld1", 1, 4, 7'h11, 8'h7F);
        chk("t1_set_count", set_cyc.size(), 1);
        chk_at("t1_set_cyc", set_cyc, 0, 6);
        chk("t1_done_count", done_cyc.size(), 1);
        chk_at("t1_done_cyc", done_cyc, 0, 11);
        chk("t1_addr_hold", dly_addr, 7'h11);
        chk("t1_data_hold", dly_data, 8'h7F);

        // Fill the FIFO, reject a ninth write, then drain it
        for (int i = 0; i < 8; i++) begin
            push(7'(8'h20 + i), 8'(3 * i + 1));
            chk($sformatf("t2_ready_after_%0d", i + 1), wr_ready, (i < 7) ? 1 : 0);
        end
        push(7'h7E, 8'hEE);
        chk("t2_ready_after_9th", wr_ready, 0);
        do_commit();
        observe(30);
        chk("t2_ld_count", ld_cyc.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_ld($sformatf("t2_ld%0d", i), i, 2 + 2 * i, 7'(8'h20 + i), 8'(3 * i + 1));
        chk("t2_ready_c1", rdy_at[1], 0);
        chk("t2_ready_c2", rdy_at[2], 1);
        chk("t2_set_count", set_cyc.size(), 1);
        chk_at("t2_set_cyc", set_cyc, 0, 18);
        chk_at("t2_done_cyc", done_cyc, 0, 23);

        // Empty commit re-applies with set only
        do_commit();
        observe(12);
        chk("t3_ld_count", ld_cyc.size(), 0);
        chk("t3_set_count", set_cyc.size(), 1);
        chk_at("t3_set_cyc", set_cyc, 0, 2);
        chk_at("t3_done_cyc", done_cyc, 0, 7);

        // Push during LOAD and commit during SETTLE
        push(7'h01, 8'h11);
        do_commit();
        clear_obs();
        for (int c = 1; c <= 24; c++) begin
            wr_valid = (c == 2);
            wr_addr  = 7'h02;
            wr_data  = 8'h22;
            commit   = (c == 5);
            tick();
            sample(c);
        end
        wr_valid = 1'b0;
        commit   = 1'b0;
        chk("t4_ld_count", ld_cyc.size(), 2);
        chk_ld("t4_ld0", 0, 2, 7'h01, 8'h11);
        chk_ld("t4_ld1", 1, 11, 7'h02, 8'h22);
        chk("t4_set_count", set_cyc.size(), 2);
        chk_at("t4_set0", set_cyc, 0, 4);
        chk_at("t4_set1", set_cyc, 1, 13);
        chk("t4_done_count", done_cyc.size(), 2);
        chk_at("t4_done0", done_cyc, 0, 9);
        chk_at("t4_done1", done_cyc, 1, 18);
        chk("t4_idle_busy", busy, 0);

        // Async reset during GAP after the first of three loads
        push(7'h30, 8'hA0);
        push(7'h31, 8'hA1);
        push(7'h32, 8'hA2);
        do_commit();
        tick();
        tick();
        chk("t5_ld_before_rst", ld_delay, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ld_delay", ld_delay, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_set", set, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_dly_addr", dly_addr, 0);
        chk("t5_rst_dly_data", dly_data, 0);
        chk("t5_rst_wr_ready", wr_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        observe(20);
        chk("t5_post_ld_count", ld_cyc.size(), 0);
        chk("t5_post_set_count", set_cyc.size(), 0);
        chk("t5_post_busy", busy, 0);
        chk("t5_post_wr_ready", wr_ready, 1);
        do_commit();
        observe(12);
        chk("t5_flush_ld_count", ld_cyc.size(), 0);
        chk_at("t5_flush_set_cyc", set_cyc, 0, 2);

        // Readback of a loaded tap
        push(7'h40, 8'h33);
        do_commit();
        observe(15);
        chk_ld("t6_ld", 0, 2, 7'h40, 8'h33);
        rd_addr = 7'h40;
        tick();
`ifdef PHY_DLY_SEQ_READBACK_EN
        chk("t6_rd_40", rd_data, 8'h33);
`else
        chk("t6_rd_40", rd_data, 8'h00);
`endif
        rd_addr = 7'h41;
        tick();
        chk("t6_rd_41", rd_data, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phy_dly_sequencer.md
Name: phy_dly_sequencer

Overview:
- Programs the PHY's per-lane IODELAY taps through the dly_data / dly_addr / ld_delay / set interface of the PHY top.
- Accepts (address, tap) write requests into a small FIFO. On a commit request it issues the queued ld_delay strobes with a programmable gap, then one set pulse, then a settle wait, then reports completion.
- Sits between the calibration / host register logic and phy_top. Runs in the mclk domain.

Parameters:
- FIFO_DEPTH, 8, number of queued (addr,data) entries; power of 2, 2..32.
- LD_GAP, 1, idle cycles inserted after each ld_delay strobe (0..15).
- SETTLE_CYCLES, 4, cycles waited after set before done (1..255).

Ports:
- mclk, input, 1, system clock (same clock as the PHY control inputs).
- rst_n, input, 1, asynchronous active-low reset.
- wr_valid, input, 1, write request valid.
- wr_ready, output, 1, FIFO not full; a write is accepted when wr_valid && wr_ready.
- wr_addr, input, 7, delay select address.
- wr_data, input, 8, delay value (3 LSB fine).
- commit, input, 1, single-cycle request to load queued entries and apply.
- busy, output, 1, sequence in progress (state != IDLE).
- done, output, 1, one-cycle pulse at end of sequence.
- dly_addr, output, 7, to phy_top.
- dly_data, output, 8, to phy_top.
- ld_delay, output, 1, to phy_top.
- set, output, 1, to phy_top.
- rd_addr, input, 7, readback address (see Optional Feature).
- rd_data, output, 8, readback data.

Behaviour:
- All outputs registered.
- Reset values: wr_ready=1, busy=0, done=0, dly_addr=0, dly_data=0, ld_delay=0, set=0, rd_data=0. FIFO empty, commit_pending=0.
- FIFO: push on wr_valid && wr_ready. Pop only in LOAD. wr_ready = !full; a pop in the same cycle does not admit a push while full. Writes are accepted in any state.
- Commit: a commit pulse sets commit_pending. Commits while pending or busy merge (one level deep). Pending is cleared on entry to LOAD or SET from IDLE.
- Entry count: on leaving IDLE, n_load := current FIFO occupancy. Only n_load entries are loaded; entries pushed later remain for the next commit.
- States:
  - IDLE: if commit_pending and n>0, go to LOAD. If commit_pending and FIFO empty, go to SET (re-apply previous loads).
  - LOAD: drive dly_addr/dly_data from the FIFO head, ld_delay=1 for exactly this cycle, pop, decrement n_load. Next state: GAP if LD_GAP>0; else LOAD if n_load remaining >0; else SET.
  - GAP: count LD_GAP cycles with ld_delay=0, then LOAD if n_load>0, else SET.
  - SET: set=1 for exactly one cycle, then SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE. A pending commit is serviced from IDLE on the following cycle.
- dly_addr/dly_data hold their last driven value outside LOAD.
- Latency, commit in IDLE with k entries and LD_GAP=g: first ld_delay 2 cycles after the commit edge; set (k*(1+g)+2) cycles after commit; done SETTLE_CYCLES+1 cycles after set.
- Async reset mid-operation: state returns to IDLE and the FIFO is flushed immediately. Any ld_delay/set pulse in progress is cut; no further set is issued.

Optional Feature:
- Macro: PHY_DLY_SEQ_READBACK_EN.
- Defined: a 128x8 shadow register file is written with (dly_addr,dly_data) on every ld_delay cycle. rd_data = shadow[rd_addr], registered, 1-cycle latency. The shadow resets to 0.
- Not defined: no shadow storage; rd_data is constant 0; rd_addr is ignored.

Test Plan:
- Reset, then push (0x05,0x2A),(0x11,0x7F), then commit, LD_GAP=1 -> ld_delay at commit+2 (addr 05, data 2A) and commit+4 (addr 11, data 7F); set at commit+6; done at commit+11 (SETTLE=4); busy high commit+1..commit+11.
- Push 8 entries with no commit -> wr_ready=0 after the 8th; a 9th wr_valid is not accepted. Commit -> 8 strobes in order; wr_ready returns 1 after the first pop.
- Commit with FIFO empty -> no ld_delay; set at commit+2; done at commit+7.
- Commit during SETTLE, plus a push during LOAD -> after done, a second sequence loads only the newly pushed entry; exactly two set pulses in total.
- Assert rst_n low during GAP after 1 of 3 loads -> all outputs at reset values at once; no set pulse; FIFO empty (wr_ready=1) after release.
- With PHY_DLY_SEQ_READBACK_EN: load addr 0x40 data 0x33, then rd_addr=0x40 -> rd_data=0x33 one cycle later. Without the macro -> rd_data=0.
